func_gen: RTL and testbench

- Parametrised, multi-cycle arithmetic unit computing y = a^2 + floor(cbrt(b)) on unsigned WIDTH-bit operands.
- Next generation of the 8-bit start/busy function block: generic WIDTH, a shared iterative multiplier, an overflow flag, a done pulse and operand latching.
- Sits behind a simple start/busy handshake driven by a controller or a testbench.

---
 rtl/func_gen.sv | 169 ++++++++++++++++
 tb/tb_func_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/func_gen.sv
//------------------------------------------------------------------------------
// func_gen -- multi-cycle unsigned arithmetic unit: y = a^2 + floor(cbrt(b))
//
// Operands are latched on an accepted start. The square and every cube-root
// partial product go through one shared WIDTH x WIDTH multiplier. The cube
// root uses the restoring method, with three states per result bit.
//
// Optional build macro: FUNC_GEN_SAT_EN
//   defined   : an overflowing result saturates y_bo to all ones
//   undefined : an overflowing result wraps modulo 2^WIDTH
//   overflow_o is set on overflow in both builds.
//
// Ports:
//   clk_i       in   1      clock, rising edge
//   rst_i       in   1      asynchronous active-low reset
//   a           in   WIDTH  operand to be squared
//   b           in   WIDTH  operand for the cube root
//   start_i     in   1      request, accepted only while idle
//   busy_o      out  1      computation in progress (2+3*ITER cycles)
//   done_o      out  1      one-cycle pulse when y_bo updates
//   overflow_o  out  1      exact result >= 2^WIDTH, valid with y_bo
//   y_bo        out  WIDTH  result, held until the next completion
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module func_gen #(
  parameter int WIDTH = 8,
  parameter int ITER  = (WIDTH + 2) / 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [WIDTH-1:0] y_bo
);

  localparam int PW = 2 * WIDTH;      // product / square width
  localparam int BW = 3 * WIDTH + 2;  // cube-root bound width
  localparam int RW = 2 * WIDTH + 1;  // final sum width

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_CB_MUL,
    S_CB_BND,
    S_CB_CMP,
    S_ADD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_sq;
  logic [PW-1:0]    r_t;
  logic [BW-1:0]    r_bnd;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [7:0]       r_shift;

  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_mul_b;
  logic [PW-1:0]    w_prod;
  logic [BW-1:0]    w_t3p1;
  logic [BW-1:0]    w_bnd;
  logic             w_ge;
  logic [RW-1:0]    w_sum;
  logic             w_ovf;

  assign busy_o = (r_state != S_IDLE);

  // Single shared multiplier: a_r*a_r in SQR, (2y)*(2y+1) otherwise.
  // y never exceeds ITER bits, so 2y+1 fits in WIDTH bits.
  always_comb begin
    w_mul_a = r_a;
    w_mul_b = r_a;
    if (r_state != S_SQR) begin
      w_mul_a = {r_y[WIDTH-2:0], 1'b0};
      w_mul_b = {r_y[WIDTH-2:0], 1'b1};
    end
  end

  assign w_prod = PW'(w_mul_a) * PW'(w_mul_b);

  // (3t+1) << s built from shifts and adds only.
  assign w_t3p1 = (BW'(r_t) << 1) + BW'(r_t) + BW'(1);
  assign w_bnd  = w_t3p1 << r_shift;
  assign w_ge   = (BW'(r_x) >= r_bnd);

  assign w_sum  = RW'(r_sq) + RW'(r_y);
  assign w_ovf  = |w_sum[RW-1:WIDTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start_i) w_next = S_SQR;
      S_SQR:    w_next = S_CB_MUL;
      S_CB_MUL: w_next = S_CB_BND;
      S_CB_BND: w_next = S_CB_CMP;
      S_CB_CMP: w_next = (r_shift == 8'd0) ? S_ADD : S_CB_MUL;
      S_ADD:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sq       <= '0;
      r_t        <= '0;
      r_bnd      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_shift    <= '0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      y_bo       <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_SQR: begin
          r_sq    <= w_prod;
          r_x     <= r_b;
          r_y     <= '0;
          r_shift <= 8'(3 * (ITER - 1));
        end
        S_CB_MUL: r_t   <= w_prod;
        S_CB_BND: r_bnd <= w_bnd;
        S_CB_CMP: begin
          if (w_ge) begin
            r_x <= r_x - r_bnd[WIDTH-1:0];
            r_y <= {r_y[WIDTH-2:0], 1'b1};
          end else begin
            r_y <= {r_y[WIDTH-2:0], 1'b0};
          end
          r_shift <= r_shift - 8'd3;
        end
        S_ADD: begin
          done_o     <= 1'b1;
          overflow_o <= w_ovf;
`ifdef FUNC_GEN_SAT_EN
          y_bo       <= w_ovf ? '1 : w_sum[WIDTH-1:0];
`else
          y_bo       <= w_sum[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_func_gen.sv
//------------------------------------------------------------------------------
// tb_func_gen -- directed self-checking bench for func_gen (WIDTH=8 and 12).
// Expected results are hand-computed constants. Overflow expectation follows
// the FUNC_GEN_SAT_EN build macro.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_func_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a8, b8, y8;
  logic       st8, busy8, done8, ovf8;
  logic [11:0] a12, b12, y12;
  logic        st12, busy12, done12, ovf12;

  int checks   = 0;
  int failures = 0;

`ifdef FUNC_GEN_SAT_EN
  localparam logic [7:0] OVF_Y = 8'd255;
`else
  localparam logic [7:0] OVF_Y = 8'd3;
`endif

  func_gen #(.WIDTH(8)) u_dut8 (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .a          (a8),
    .b          (b8),
    .start_i    (st8),
    .busy_o     (busy8),
    .done_o     (done8),
    .overflow_o (ovf8),
    .y_bo       (y8)
  );

  func_gen #(.WIDTH(12)) u_dut12 (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .a          (a12),
    .b          (b12),
    .start_i    (st12),
    .busy_o     (busy12),
    .done_o     (done12),
    .overflow_o (ovf12),
    .y_bo       (y12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation. With poke set, a/b change and start pulses
  // mid-operation; neither may affect the result or the latency.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ey, input logic eo, input bit poke);
    int n;
    int dn;
    a8  = av;
    b8  = bv;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy8), 32'd1);
    n  = 1;
    dn = 0;
    while (busy8 && n < 40) begin
      if (poke && n == 3) begin
        a8  = 8'd200;
        b8  = 8'd0;
        st8 = 1'b1;
      end
      @(posedge clk); #1;
      st8 = 1'b0;
      if (done8) dn++;
      if (busy8) n++;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd11);
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_y"}, 32'(y8), 32'(ey));
    check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    @(posedge clk); #1;
    if (done8) dn++;
    check({tag, "_done_count"}, 32'(dn), 32'd1);
    check({tag, "_idle"}, 32'(busy8), 32'd0);
  endtask

  initial begin : stim
    int n;
    int dn;
    rst_n = 1'b1;
    st8 = 1'b0; a8 = '0; b8 = '0;
    st12 = 1'b0; a12 = '0; b12 = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_ovf",  32'(ovf8),  32'd0);
    check("rst_y",    32'(y8),    32'd0);
    check("rst_y12",  32'(y12),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8("a0_b1",    8'd0,  8'd1,   8'd1,   1'b0, 1'b0);
    op8("a15_b255", 8'd15, 8'd255, 8'd231, 1'b0, 1'b0);
    op8("a8_b64",   8'd8,  8'd64,  8'd68,  1'b0, 1'b0);
    op8("a0_b0",    8'd0,  8'd0,   8'd0,   1'b0, 1'b0);
    op8("a16_b27",  8'd16, 8'd27,  OVF_Y,  1'b1, 1'b0);
    op8("hold",     8'd8,  8'd64,  8'd68,  1'b0, 1'b1);

    // Reset in the 5th busy cycle; y8 holds 68 beforehand.
    a8 = 8'd8; b8 = 8'd64; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_y",    32'(y8),    32'd0);
    check("midrst_ovf",  32'(ovf8),  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8 || busy8) dn++;
    end
    check("midrst_no_resume", 32'(dn), 32'd0);
    op8("after_rst", 8'd3, 8'd8, 8'd11, 1'b0, 1'b0);

    // WIDTH=12: 40^2 + 15 = 1615
    a12 = 12'd40; b12 = 12'd4095; st12 = 1'b1;
    @(posedge clk); #1;
    st12 = 1'b0;
    n = 1;
    while (busy12 && n < 60) begin
      @(posedge clk); #1;
      if (busy12) n++;
    end
    check("w12_busy_cycles", 32'(n), 32'd14);
    check("w12_done", 32'(done12), 32'd1);
    check("w12_y",    32'(y12),    32'd1615);
    check("w12_ovf",  32'(ovf12),  32'd0);
    @(posedge clk); #1;

    // Back-to-back with start held high: 2^2 + 5 = 9 every 12 cycles.
    a8 = 8'd2; b8 = 8'd125; st8 = 1'b1;
    @(posedge clk); #1;
    check("b2b_busy_rise", 32'(busy8), 32'd1);
    for (int i = 0; i < 3; i++) begin
      n = 1;
      while (busy8 && n < 40) begin
        @(posedge clk); #1;
        if (busy8) n++;
      end
      check($sformatf("b2b%0d_busy_cycles", i), 32'(n), 32'd11);
      check($sformatf("b2b%0d_done", i), 32'(done8), 32'd1);
      check($sformatf("b2b%0d_y", i), 32'(y8), 32'd9);
      if (i == 2) st8 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("b2b%0d_next_busy", i), 32'(busy8), (i == 2) ? 32'd0 : 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
